// File: rtl/decode_stage.sv
// RV32I decode: register file, immediate generator and control decode, registered into ID/EX.
// Define DECODE_BYPASS_EN to make a same-cycle writeback visible to the register reads.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] PCD,
    input  logic            RegWriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmE,
    output logic [XLEN-1:0] PCE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic [3:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [2:0]      funct3E,
    output logic            illegalE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    idex_t           dec;
    idex_t           idex;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign rs1    = instrD[19:15];
    assign rs2    = instrD[24:20];
    assign rd     = instrD[11:7];

    // Register file; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (RegWriteW && rdW != 5'd0) begin
            rf[rdW] <= ResultW;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rd1 = (rs1 == 5'd0) ? '0 :
                 (RegWriteW && rdW == rs1) ? ResultW : rf[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 :
                 (RegWriteW && rdW == rs2) ? ResultW : rf[rs2];
`else
    assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];
`endif

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-12){instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {{(XLEN-32){instrD[31]}}, instrD[31:12], 12'b0};
            OP_JAL:
                imm = {{(XLEN-20){instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic bit30, input logic is_r);
        case (f3)
            3'b000:  alu_op = (is_r && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec        = '0;
        dec.rd1    = rd1;
        dec.rd2    = rd2;
        dec.imm    = imm;
        dec.pc     = PCD;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd     = rd;
        dec.funct3 = funct3;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_op(funct3, instrD[30], 1'b1);
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_op(funct3, instrD[30], 1'b0);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'd1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'd2;
            end
            OP_JALR: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'd2;
            end
            OP_LUI: begin
                // rs1 bits are immediate here; zero operand A so execute's ADD yields the immediate.
                dec.rd1       = '0;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: dec.illegal = (instrD != 32'd0);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex <= '0;
        end else if (flush) begin
            idex <= '0;
        end else if (!stall) begin
            idex <= dec;
        end
    end

    assign RD1E        = idex.rd1;
    assign RD2E        = idex.rd2;
    assign ImmE        = idex.imm;
    assign PCE         = idex.pc;
    assign rs1E        = idex.rs1;
    assign rs2E        = idex.rs2;
    assign rdE         = idex.rd;
    assign ALUControlE = idex.alu_ctrl;
    assign ALUSrcE     = idex.alu_src;
    assign RegWriteE   = idex.reg_write;
    assign MemWriteE   = idex.mem_write;
    assign ResultSrcE  = idex.result_src;
    assign BranchE     = idex.branch;
    assign JumpE       = idex.jump;
    assign funct3E     = idex.funct3;
    assign illegalE    = idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: regfile, immediates, control decode, stall/flush and reset.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] ResultW;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmE;
    logic [31:0] PCE;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        BranchE;
    logic        JumpE;
    logic [2:0]  funct3E;
    logic        illegalE;

    int checks   = 0;
    int failures = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .instrD(instrD), .PCD(PCD),
        .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCE(PCE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .JumpE(JumpE), .funct3E(funct3E), .illegalE(illegalE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] instr,
                           input logic [3:0] alu, input logic src, input logic rw,
                           input logic mw, input logic [1:0] rs, input logic jmp,
                           input logic br, input logic [31:0] imm);
        instrD = instr;
        tick();
        check({tag, "_alu"}, 32'(ALUControlE), 32'(alu));
        check({tag, "_src"}, 32'(ALUSrcE), 32'(src));
        check({tag, "_rw"},  32'(RegWriteE), 32'(rw));
        check({tag, "_mw"},  32'(MemWriteE), 32'(mw));
        check({tag, "_res"}, 32'(ResultSrcE), 32'(rs));
        check({tag, "_jmp"}, 32'(JumpE), 32'(jmp));
        check({tag, "_br"},  32'(BranchE), 32'(br));
        check({tag, "_imm"}, ImmE, imm);
        check({tag, "_ill"}, 32'(illegalE), 32'd0);
    endtask

    logic [31:0] exp_byp;
    logic [31:0] held_pc;

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        instrD = 32'd0; PCD = 32'd0;
        RegWriteW = 1'b0; rdW = 5'd0; ResultW = 32'd0;
        #3;
        check("rst_rd1", RD1E, 32'd0);
        check("rst_imm", ImmE, 32'd0);
        check("rst_pc",  PCE, 32'd0);
        check("rst_rw",  32'(RegWriteE), 32'd0);
        #4 rst = 1'b0;
        tick();

        // Writeback x5, then ADDI x6,x5,-1 reads it
        RegWriteW = 1'b1; rdW = 5'd5; ResultW = 32'hDEADBEEF;
        tick();
        RegWriteW = 1'b0;
        instrD = 32'hFFF28313; PCD = 32'h0000_0100;
        tick();
        check("addi_rd1", RD1E, 32'hDEADBEEF);
        check("addi_imm", ImmE, 32'hFFFFFFFF);
        check("addi_alu", 32'(ALUControlE), 32'd0);
        check("addi_src", 32'(ALUSrcE), 32'd1);
        check("addi_rw",  32'(RegWriteE), 32'd1);
        check("addi_rd",  32'(rdE), 32'd6);
        check("addi_rs1", 32'(rs1E), 32'd5);
        check("addi_pc",  PCE, 32'h0000_0100);

        // BEQ x0,x0,-8
        instrD = 32'hFE000CE3; PCD = 32'h0000_0104;
        tick();
        check("beq_imm", ImmE, 32'hFFFFFFF8);
        check("beq_br",  32'(BranchE), 32'd1);
        check("beq_alu", 32'(ALUControlE), 32'd1);
        check("beq_rw",  32'(RegWriteE), 32'd0);
        check("beq_src", 32'(ALUSrcE), 32'd0);
        check("beq_f3",  32'(funct3E), 32'd0);

        // Stall two cycles, then flush wins over stall
        held_pc = PCE;
        stall = 1'b1; instrD = 32'hFFF28313; PCD = 32'h0000_0200;
        tick();
        tick();
        check("stall_imm", ImmE, 32'hFFFFFFF8);
        check("stall_br",  32'(BranchE), 32'd1);
        check("stall_pc",  PCE, held_pc);
        check("stall_alu", 32'(ALUControlE), 32'd1);
        flush = 1'b1;
        tick();
        check("flush_imm", ImmE, 32'd0);
        check("flush_br",  32'(BranchE), 32'd0);
        check("flush_pc",  PCE, 32'd0);
        check("flush_rd1", RD1E, 32'd0);
        check("flush_rw",  32'(RegWriteE), 32'd0);
        flush = 1'b0; stall = 1'b0;

        // ALU / format decode table
        run_vec("sub",   32'h403100B3, 4'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        run_vec("sra",   32'h403150B3, 4'd9, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        run_vec("srl",   32'h003150B3, 4'd8, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        run_vec("and",   32'h003170B3, 4'd2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        run_vec("srai",  32'h40315093, 4'd9, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_0403);
        run_vec("addi4", 32'h40010093, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_0400);
        run_vec("lw",    32'hFFC12083, 4'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'hFFFFFFFC);
        run_vec("sw",    32'h00312423, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0000_0008);
        run_vec("jal",   32'h010000EF, 4'd0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0000_0010);
        run_vec("jalr",  32'h004100E7, 4'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0000_0004);
        run_vec("lui",   32'h123450B7, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h12345000);
        run_vec("auipc", 32'hFFFFF097, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'hFFFFF000);

        // x0 write ignored, both in the same cycle and afterwards
        RegWriteW = 1'b1; rdW = 5'd0; ResultW = 32'h0000_1234;
        instrD = 32'h0000_0013;
        tick();
        check("x0_same", RD1E, 32'd0);
        RegWriteW = 1'b0;
        tick();
        check("x0_after", RD1E, 32'd0);

        // Unknown opcode and fetch bubble
        instrD = 32'h0000_007F;
        tick();
        check("ill_flag", 32'(illegalE), 32'd1);
        check("ill_rw",   32'(RegWriteE), 32'd0);
        check("ill_mw",   32'(MemWriteE), 32'd0);
        check("ill_br",   32'(BranchE), 32'd0);
        check("ill_jmp",  32'(JumpE), 32'd0);
        instrD = 32'd0;
        tick();
        check("bub_ill", 32'(illegalE), 32'd0);
        check("bub_rw",  32'(RegWriteE), 32'd0);

        // Same-cycle write and read of x7
        RegWriteW = 1'b1; rdW = 5'd7; ResultW = 32'h1111_1111;
        tick();
        ResultW = 32'hA5A5A5A5;
        instrD = 32'h0003_8413;
`ifdef DECODE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h1111_1111;
`endif
        tick();
        check("x7_same", RD1E, exp_byp);
        RegWriteW = 1'b0;
        tick();
        check("x7_after", RD1E, 32'hA5A5A5A5);

        // Asynchronous reset mid-run
        PCD = 32'h0000_0300;
        #2 rst = 1'b1;
        #1;
        check("arst_rd1", RD1E, 32'd0);
        check("arst_rw",  32'(RegWriteE), 32'd0);
        check("arst_pc",  PCE, 32'd0);
        check("arst_rd",  32'(rdE), 32'd0);
        #1 rst = 1'b0;
        for (int r = 1; r < 32; r++) begin
            instrD = (32'(r) << 15) | (32'(32 - r) << 20) | 32'h0000_0033;
            tick();
            check($sformatf("clr_rs1_x%0d", r), RD1E, 32'd0);
            check($sformatf("clr_rs2_x%0d", 32 - r), RD2E, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
